// File: rtl/rr_arb_mux_if.sv
// Bundle of the N request channels and the single registered output port of rr_arb_mux.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_id,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
    output out_ready
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel round-robin valid/ready arbiter feeding one registered output beat.
// One beat per cycle sustained; the search starts at ptr and advances only on an accepted beat.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int IDW = $clog2(N);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [IDW-1:0]   out_id_q,    out_id_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] chan_data [N];

  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority search: candidate k is (ptr + k) mod N, first valid wins.
  always_comb begin
    logic [IDW:0] cand;
    // NOTE: every comb output gets a default before any conditional path, so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!grant_found && bus.in_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_valid_d = 1'b1;
        out_data_d  = chan_data[grant_idx];
        out_id_d    = grant_idx;
        ptr_d       = (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        // Idle: data, id and ptr hold so nothing depends on unused in_data.
        out_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  // Held in reset, no channel may believe its beat was taken.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load_en && grant_found) begin
      bus.in_ready = N'(1) << grant_idx;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (N=4, WIDTH=32): reset, fairness, wrap/skip, stall, idle.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  rr_arb_mux_if #(.WIDTH(32), .N(4)) bus ();

  rr_arb_mux #(.WIDTH(32), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered outputs are sampled then too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int ch, input logic [31:0] v);
    bus.in_data[ch*32 +: 32] = v;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] id);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"},  bus.out_data,       d);
    check({tag, "_id"},    32'(bus.out_id),    32'(id));
  endtask

  task automatic check_ready(input string tag, input logic [3:0] exp);
    #1;
    check(tag, 32'(bus.in_ready), 32'(exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(i, 32'hA0 + 32'(i));

    // Reset held through two edges with every channel requesting
    tick();
    tick();
    check_out("rst", 1'b0, 32'h0, 2'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b1;

    // Fairness from ptr=0: 0,1,2,3,0,1 back to back
    tick(); check_out("rr0", 1'b1, 32'hA0, 2'd0);
    tick(); check_out("rr1", 1'b1, 32'hA1, 2'd1);
    tick(); check_out("rr2", 1'b1, 32'hA2, 2'd2);
    tick(); check_out("rr3", 1'b1, 32'hA3, 2'd3);
    tick(); check_out("rr4", 1'b1, 32'hA0, 2'd0);
    tick(); check_out("rr5", 1'b1, 32'hA1, 2'd1);

    // Single channel 2 (ptr=2)
    bus.in_valid = 4'b0100;
    put(2, 32'hDEADBEEF);
    check_ready("single_ready", 4'b0100);
    tick(); check_out("single", 1'b1, 32'hDEADBEEF, 2'd2);

    // Wrap and skip: ptr=3 with channels 0,1 -> 0, then 1, then 0
    bus.in_valid = 4'b0011;
    put(0, 32'hC0);
    put(1, 32'hC1);
    check_ready("wrap_ready", 4'b0001);
    tick(); check_out("wrap", 1'b1, 32'hC0, 2'd0);
    check_ready("skip1_ready", 4'b0010);
    tick(); check_out("skip1", 1'b1, 32'hC1, 2'd1);
    check_ready("skip0_ready", 4'b0001);
    tick(); check_out("skip0", 1'b1, 32'hC0, 2'd0);

    // Load beat 1111 from channel 1 (ptr=1 -> 2)
    bus.in_valid = 4'b0010;
    put(1, 32'h1111);
    check_ready("bp_load_ready", 4'b0010);
    tick(); check_out("bp_load", 1'b1, 32'h1111, 2'd1);

    // Back-pressure for 5 cycles with all channels requesting
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      check_ready("stall_ready", 4'b0000);
      tick(); check_out("stall", 1'b1, 32'h1111, 2'd1);
    end
    bus.out_ready = 1'b1;
    check_ready("unstall_ready", 4'b0100);
    tick(); check_out("unstall", 1'b1, 32'hDEADBEEF, 2'd2);

    // Single beat on channel 3, then idle bubble with undefined data
    bus.in_valid = 4'b1000;
    put(3, 32'h33333333);
    check_ready("last_ready", 4'b1000);
    tick(); check_out("last", 1'b1, 32'h33333333, 2'd3);
    bus.in_valid = 4'b0000;
    bus.in_data  = 'x;
    check_ready("idle_ready", 4'b0000);
    tick(); check_out("idle0", 1'b0, 32'h33333333, 2'd3);
    tick(); check_out("idle1", 1'b0, 32'h33333333, 2'd3);

    // ptr wrapped to 0 after channel 3
    for (int i = 0; i < 4; i++) put(i, 32'hB0 + 32'(i));
    bus.in_valid = 4'b1111;
    check_ready("resume_ready", 4'b0001);
    tick(); check_out("resume", 1'b1, 32'hB0, 2'd0);

    // Asynchronous reset mid-stream drops the held beat
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 2'd0);
    check("async_rst_ready", 32'(bus.in_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, valid/ready successor to the 2:1 datapath mux.
- Arbitrates N requesters, for example instruction-fetch and load/store memory requests, onto one shared downstream port.
- Arbitration is fair round-robin. Transfers pass through a registered output stage.
- Sits between RV32I pipeline request sources and a single-ported memory or bus interface.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2).
- IDW, $clog2(N), width of the granted-channel index (derived localparam; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  bit i: channel i presents data.
- in_data  input  N*WIDTH  channel i data occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i: channel i transfer accepted this cycle.
- out_valid  output  1  output register holds a valid beat.
- out_data  output  WIDTH  registered data of the granted channel.
- out_id  output  IDW  index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the current beat.

Behaviour:
- Reset: on rst_n low, immediately and asynchronously set out_valid=0, out_data=0, out_id=0, and round-robin pointer ptr=0. Reset mid-transfer drops the held beat; no replay.
- Handshake: an input transfer on channel i occurs when in_valid[i] && in_ready[i]. An output transfer occurs when out_valid && out_ready.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en=1.
- Grant: when load_en=1 and at least one in_valid bit is set, exactly one channel g is granted. g is the first set bit of in_valid searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N).
- in_ready: in_ready[g]=1 for the granted channel only; all other in_ready bits are 0. All in_ready bits are 0 when load_en=0 or in_valid=0.
  - in_ready is combinational from in_valid, ptr and out_ready. Upstream must not make in_valid depend on in_ready.
- On an input transfer at edge: out_data<=in_data[g], out_id<=g, out_valid<=1, ptr<=(g+1) mod N. Wrap: g=N-1 gives ptr=0.
- When load_en=1 and no in_valid bit is set: out_valid<=0; out_data, out_id and ptr hold.
- When out_valid=1 and out_ready=0 (stall): out_valid, out_data, out_id and ptr hold. No in_ready is asserted.
- Simultaneous output consume and new input accept in the same cycle is allowed: 1 beat per cycle sustained throughput.
- Latency: exactly 1 cycle from input transfer to out_valid with that data.
- ptr advances only on an input transfer, never on idle or stall cycles.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle ptr, ptr+1, ..., each channel once per N beats.
- Upstream rule: in_valid[i] once asserted must remain high, with in_data stable, until accepted. The block does not check this.
- No X propagation: with in_valid all 0, outputs do not depend on in_data.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 and in_data[i]=32'hA0+i, then release -> during reset out_valid=0, out_data=0, out_id=0, in_ready=0. First edge after release -> out_data=32'hA0, out_id=0.
- Single channel: only in_valid[2]=1, in_data=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100 the same cycle. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_id=2; ptr becomes 3.
- Round-robin fairness: in_valid=4'b1111 continuously, out_ready=1, from reset -> out_id sequence 0,1,2,3,0,1,... one per cycle with out_valid=1 every cycle.
- Wrap and skip: ptr=3, in_valid=4'b0011 -> channel 0 granted (wrap past 3). Then ptr=1 -> channel 1 granted, then channel 0.
- Back-pressure: out_valid=1 with out_id=1 and out_data=32'h1111, out_ready=0 for 5 cycles while in_valid=4'b1111 -> in_ready=0, out_data and out_id stable, ptr unchanged. Raise out_ready -> the same cycle in_ready=4'b0100 (ptr=2).
- Bubble then idle: a single beat on channel 3 with out_ready=1, then in_valid=0 -> out_valid 1 for one cycle then 0. Next grant with in_valid=4'b1111 goes to channel 0 (ptr wrapped to 0).
